// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared types and helpers for the program-counter sequencer.
//   op_e       - decoded control-transfer operation for one cycle
//   decode_op  - priority encoder PL > RET > JB > branch test
//   sext32     - sign-extend the low w bits of a 32-bit value
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_SEQ,
    OP_RET,
    OP_JMP,
    OP_BR_TAKEN,
    OP_BR_NT
  } op_e;

  // RET outranks JB so a RET with JB set never pushes.
  function automatic op_e decode_op(input logic pl, input logic ret,
                                    input logic jb, input logic taken);
    if (!pl)   return OP_SEQ;
    if (ret)   return OP_RET;
    if (jb)    return OP_JMP;
    if (taken) return OP_BR_TAKEN;
    return OP_BR_NT;
  endfunction

  // w must be in 1..32; bits above w are replaced by copies of bit w-1.
  function automatic logic [31:0] sext32(input logic [31:0] v, input int unsigned w);
    logic [31:0] hi;
    logic        msb;
    hi  = ~32'd0 << w;
    msb = v[5'(w - 1)];
    return msb ? (v | hi) : (v & ~hi);
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// pc_ret_stack: LIFO of return addresses.
//   CLK, RST  - clock, synchronous active-high reset (clears SP only)
//   push, pop - push din / pop top; ignored when full / empty respectively
//   din, dout - entry to push / current top entry (0 when empty)
//   empty     - SP == 0
//   full      - SP == SD
//   sp        - stack pointer (number of valid entries)
module pc_ret_stack #(
  parameter int unsigned AW = 8,
  parameter int unsigned SD = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       push,
  input  logic                       pop,
  input  logic [AW-1:0]              din,
  output logic [AW-1:0]              dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(SD+1)-1:0]    sp
);
  import pc_sequencer_pkg::*;

  localparam int unsigned SPW = $clog2(SD + 1);

  logic [AW-1:0] mem [SD];

  assign empty = (sp == '0);
  assign full  = (sp == SPW'(SD));

  always_ff @(posedge CLK) begin
    if (RST)                sp <= '0;
    else if (push && !full) sp <= sp + SPW'(1);
    else if (pop && !empty) sp <= sp - SPW'(1);
  end

  // Entries carry no reset; only SP defines validity.
  always_ff @(posedge CLK) begin
    if (!RST && push && !full) begin
      for (int i = 0; i < int'(SD); i++)
        if (SPW'(i) == sp) mem[i] <= din;
    end
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < int'(SD); i++)
      if (SPW'(i + 1) == sp) dout = mem[i];
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: parametrised program counter with relative branches,
// absolute jumps and call/return through an internal return stack.
//   CLK, RST             - clock, synchronous active-high reset
//   EN                   - 0 holds all state
//   PL                   - 0 sequential step, 1 control transfer
//   JB, CALL, RET        - jump / push-before-jump / pop into PC
//   BC                   - branch test: 1 = AData negative, 0 = AData zero
//   LAddress, RAddress   - upper / lower halves of signed relative offset
//   AData                - jump target and branch test operand
//   PC                   - registered program counter
//   STK_EMPTY, STK_FULL  - return stack status
//   ERR                  - sticky overflow/underflow flag
// AW is limited to 32 by the sign-extend helper.
module pc_sequencer #(
  parameter int unsigned AW        = 8,
  parameter int unsigned FW        = 2,
  parameter int unsigned INC       = 1,
  parameter int unsigned RESET_VEC = 0,
  parameter int unsigned SD        = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic          PL,
  input  logic          JB,
  input  logic          BC,
  input  logic          CALL,
  input  logic          RET,
  input  logic [FW-1:0] LAddress,
  input  logic [FW-1:0] RAddress,
  input  logic [AW-1:0] AData,
  output logic [AW-1:0] PC,
  output logic          STK_EMPTY,
  output logic          STK_FULL,
  output logic          ERR
);
  import pc_sequencer_pkg::*;

  localparam int unsigned OW  = 2 * FW;
  localparam int unsigned SPW = $clog2(SD + 1);

  logic [OW-1:0]  off_raw;
  logic [AW-1:0]  off;
  logic [AW-1:0]  pc_inc;
  logic [AW-1:0]  pc_nxt;
  logic           taken;
  op_e            op;
  logic           push, pop, err_set;
  logic [AW-1:0]  stk_top;
  logic           stk_empty, stk_full;
  logic [SPW-1:0] stk_sp;

  assign off_raw = {LAddress, RAddress};
  assign off     = AW'(sext32(32'(off_raw), OW));
  assign pc_inc  = PC + AW'(INC);
  assign taken   = BC ? AData[AW-1] : (AData == '0);
  assign op      = decode_op(PL, RET, JB, taken);

  // Sums wrap modulo 2^AW by construction of the AW-wide adders.
  always_comb begin
    pc_nxt  = pc_inc;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    case (op)
      OP_SEQ:      pc_nxt = pc_inc;
      OP_RET: begin
        if (stk_sp != '0) begin
          pc_nxt = stk_top;
          pop    = 1'b1;
        end else begin
          pc_nxt  = pc_inc;
          err_set = 1'b1;
        end
      end
      OP_JMP: begin
        pc_nxt = AData;
        if (CALL) begin
          // Full stack drops the push but still takes the jump.
          if (stk_sp == SPW'(SD)) err_set = 1'b1;
          else                    push    = 1'b1;
        end
      end
      OP_BR_TAKEN: pc_nxt = PC + off;
      OP_BR_NT:    pc_nxt = pc_inc;
      default:     pc_nxt = pc_inc;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      PC  <= AW'(RESET_VEC);
      ERR <= 1'b0;
    end else if (EN) begin
      PC <= pc_nxt;
      if (err_set) ERR <= 1'b1;
    end
  end

  pc_ret_stack #(.AW(AW), .SD(SD)) u_stk (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push & EN),
    .pop   (pop & EN),
    .din   (pc_inc),
    .dout  (stk_top),
    .empty (stk_empty),
    .full  (stk_full),
    .sp    (stk_sp)
  );

  assign STK_EMPTY = stk_empty;
  assign STK_FULL  = stk_full;

endmodule
